// File: rtl/dff_cla_5bit.sv
//------------------------------------------------------------------------------
// Module   : dff_cla_5bit (with helper dff_ar)
// Purpose  : Registered 5-bit carry-look-ahead adder. Operands and carry-in
//            are captured in a first flop stage. A fully flattened CLA then
//            adds them. The result is captured in a second flop stage.
//            Fixed latency is 2 rising edges, and a new operation can start
//            every cycle.
// Ports    : clk   - single clock, rising-edge triggered
//            reset - asynchronous, active-low clear of every flop
//            A, B  - 5-bit unsigned addends
//            Cin   - carry in
//            Sum   - registered (A+B+Cin)[4:0]
//            Cout  - registered (A+B+Cin)[5]
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

// Single-bit D flip-flop with asynchronous active-low clear. This is the only
// storage primitive used by the adder.
module dff_ar (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end

endmodule

module dff_cla_5bit (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic       Cin,
  output logic [4:0] Sum,
  output logic       Cout
);

  localparam int WIDTH = 5;

  // Stage 1 operand registers
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cin_r;

  // CLA internals
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;

  // Stage 2 result registers
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  //----------------------------------------------------------------------------
  // Stage 1: capture operands
  //----------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage1
    dff_ar u_a (.clk(clk), .reset(reset), .d(A[i]), .q(a_r[i]));
    dff_ar u_b (.clk(clk), .reset(reset), .d(B[i]), .q(b_r[i]));
  end

  dff_ar u_cin (.clk(clk), .reset(reset), .d(Cin), .q(cin_r));

  //----------------------------------------------------------------------------
  // Combinational CLA. Each carry is written as a flat sum of products of the
  // generate/propagate terms and cin_r. No carry depends on another carry, so
  // the depth is the same for every bit.
  //----------------------------------------------------------------------------
  assign g = a_r & b_r;
  assign p = a_r ^ b_r;

  assign c[0] = cin_r;

  assign c[1] = g[0]
              | (p[0] & c[0]);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c[0]);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);

  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign c[5] = g[4]
              | (p[4] & g[3])
              | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum_d = p ^ c[WIDTH-1:0];

  //----------------------------------------------------------------------------
  // Stage 2: capture result
  //----------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage2
    dff_ar u_sum (.clk(clk), .reset(reset), .d(sum_d[i]), .q(sum_q[i]));
  end

  dff_ar u_cout (.clk(clk), .reset(reset), .d(c[WIDTH]), .q(cout_q));

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_dff_cla_5bit.sv
//------------------------------------------------------------------------------
// Module   : tb_dff_cla_5bit
// Purpose  : Self-checking bench for dff_cla_5bit. The reference is plain
//            integer addition A+B+Cin, checked 2 rising edges after the
//            operands are sampled.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dff_cla_5bit;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] A     = 5'd0;
  logic [4:0] B     = 5'd0;
  logic       Cin   = 1'b0;
  logic [4:0] Sum;
  logic       Cout;

  int checks = 0;
  int passed = 0;

  dff_cla_5bit dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sum  (Sum),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  // Reference model: unsigned 6-bit result of A+B+Cin
  function automatic logic [5:0] ref_add(input int a, input int b, input int ci);
    int s;
    s = a + b + ci;
    return 6'(s);
  endfunction

  // Hold reset low with all-ones operands; outputs must stay cleared.
  task automatic test_reset();
    A = 5'd31; B = 5'd31; Cin = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({Cout, Sum} !== 6'd0)
      $display("FAIL reset_initial: got %0d expected 0", {Cout, Sum});
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({Cout, Sum} !== 6'd0)
        $display("FAIL reset_hold cycle %0d: got %0d expected 0", i, {Cout, Sum});
      else passed++;
    end
  endtask

  // Release reset; result must not show after edge N, only after N+1.
  task automatic test_basic_latency();
    @(negedge clk);
    reset = 1'b1;
    A = 5'd1; B = 5'd2; Cin = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({Cout, Sum} !== 6'd0)
      $display("FAIL latency_early: got %0d expected 0", {Cout, Sum});
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({Cout, Sum} !== 6'd3)
      $display("FAIL latency_basic: got %0d expected 3", {Cout, Sum});
    else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    A = 5'd10; B = 5'd5;  Cin = 1'b0;
    @(negedge clk);
    A = 5'd15; B = 5'd15; Cin = 1'b1;
    @(negedge clk);
    checks++;
    if (Sum !== 5'd15 || Cout !== 1'b0)
      $display("FAIL b2b_first: got sum=%0d cout=%0d expected sum=15 cout=0", Sum, Cout);
    else passed++;
    @(negedge clk);
    checks++;
    if (Sum !== 5'd31 || Cout !== 1'b0)
      $display("FAIL b2b_second: got sum=%0d cout=%0d expected sum=31 cout=0", Sum, Cout);
    else passed++;
  endtask

  task automatic test_carry();
    logic [4:0] ta [3] = '{5'd31, 5'd31, 5'd31};
    logic [4:0] tb [3] = '{5'd1,  5'd0,  5'd31};
    logic       tc [3] = '{1'b0,  1'b1,  1'b1};
    logic [4:0] es [3] = '{5'd0,  5'd0,  5'd31};
    logic       ec [3] = '{1'b1,  1'b1,  1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = ta[i]; B = tb[i]; Cin = tc[i];
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (Sum !== es[i] || Cout !== ec[i])
        $display("FAIL carry_%0d: got sum=%0d cout=%0d expected sum=%0d cout=%0d",
                 i, Sum, Cout, es[i], ec[i]);
      else passed++;
    end
  endtask

  // Operands change twice between edges; only the value at the edge counts.
  task automatic test_glitch();
    @(negedge clk);
    A = 5'd20; B = 5'd7; Cin = 1'b0;
    @(negedge clk);
    A = 5'd31; B = 5'd1; Cin = 1'b0;
    #2;
    A = 5'd0;  B = 5'd0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if ({Cout, Sum} !== 6'd0)
      $display("FAIL glitch: got %0d expected 0", {Cout, Sum});
    else passed++;
  endtask

  // Reset between edges clears at once and flushes both stages.
  task automatic test_mid_reset();
    @(negedge clk);
    A = 5'd9; B = 5'd9; Cin = 1'b1;
    @(negedge clk);
    A = 5'd3; B = 5'd4; Cin = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({Cout, Sum} !== 6'd0)
      $display("FAIL midreset_async: got %0d expected 0", {Cout, Sum});
    else passed++;
    A = 5'd31; B = 5'd31; Cin = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({Cout, Sum} !== 6'd0)
      $display("FAIL midreset_hold: got %0d expected 0", {Cout, Sum});
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    A = 5'd5; B = 5'd6; Cin = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({Cout, Sum} !== 6'd0)
      $display("FAIL midreset_flush: got %0d expected 0", {Cout, Sum});
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({Cout, Sum} !== 6'd11)
      $display("FAIL midreset_resume: got %0d expected 11", {Cout, Sum});
    else passed++;
  endtask

  // All 2048 operand combinations streamed one per cycle.
  // Each result is checked two cycles after it is driven.
  task automatic test_exhaustive();
    logic [5:0] exp;
    int         k;
    int         errs = 0;
    for (int v = 0; v < 2048 + 2; v++) begin
      @(negedge clk);
      if (v >= 2) begin
        k   = v - 2;
        exp = ref_add(k % 32, (k / 32) % 32, k / 1024);
        checks++;
        if ({Cout, Sum} !== exp) begin
          errs++;
          if (errs <= 10)
            $display("FAIL exhaustive a=%0d b=%0d cin=%0d: got %0d expected %0d",
                     k % 32, (k / 32) % 32, k / 1024, {Cout, Sum}, exp);
        end else passed++;
      end
      if (v < 2048) begin
        A   = 5'(v % 32);
        B   = 5'((v / 32) % 32);
        Cin = 1'(v / 1024);
      end
    end
  endtask

  // Random back-to-back stream checked against a queue of expected sums.
  task automatic test_random();
    logic [5:0] expq [$];
    logic [5:0] exp;
    int         a, b, ci;
    int         errs = 0;
    for (int v = 0; v < 300 + 2; v++) begin
      @(negedge clk);
      if (v >= 2) begin
        exp = expq.pop_front();
        checks++;
        if ({Cout, Sum} !== exp) begin
          errs++;
          if (errs <= 10)
            $display("FAIL random op %0d: got %0d expected %0d", v - 2, {Cout, Sum}, exp);
        end else passed++;
      end
      if (v < 300) begin
        a  = int'($urandom_range(31, 0));
        b  = int'($urandom_range(31, 0));
        ci = int'($urandom_range(1, 0));
        A  = 5'(a);
        B  = 5'(b);
        Cin = 1'(ci);
        expq.push_back(ref_add(a, b, ci));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_back_to_back();
    test_carry();
    test_glitch();
    test_mid_reset();
    test_exhaustive();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
